// File: rtl/core_ctrl_pkg.sv
// rtl/core_ctrl_pkg.sv - shared state, opcode and datapath-select encodings for the multicycle core
package core_ctrl_pkg;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_EXECUTEI = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BEQ      = 4'd9;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Shared with the immediate extender; do not renumber.
    localparam logic [1:0] IMM_NONE = 2'b00;
    localparam logic [1:0] IMM_I    = 2'b01;
    localparam logic [1:0] IMM_S    = 2'b10;
    localparam logic [1:0] IMM_B    = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_READDATA  = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    function automatic logic is_supported(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_RTYPE) ||
               (op == OP_ITYPE) || (op == OP_BRANCH);
    endfunction

endpackage

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - main fetch/decode/execute sequencer for the multicycle RV32I core
module multicycle_control_fsm
    import core_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int STATE_W    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] instr,
    input  logic                  Zero,
    input  logic                  MemReady,
    output logic                  PCWrite,
    output logic                  IRWrite,
    output logic                  RegWrite,
    output logic                  MemWrite,
    output logic                  MemRead,
    output logic                  AdrSrc,
    output logic [1:0]            ResultSrc,
    output logic [1:0]            ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic [1:0]            ALUOp,
    output logic [1:0]            ImmSrc,
    output logic                  IllegalOp,
    output logic [DATA_WIDTH-1:0] InstrRetired
);

    logic [STATE_W-1:0]    state_q, state_d;
    logic [DATA_WIDTH-1:0] retired_q;
    logic                  retire;
    logic [6:0]            opcode;
    logic                  unused_instr_bits;

    assign opcode            = instr[6:0];
    assign unused_instr_bits = ^instr[DATA_WIDTH-1:7];
    assign InstrRetired      = retired_q;

    always_comb begin
        state_d = S_FETCH;
        retire  = 1'b0;
        case (state_q)
            S_FETCH:    state_d = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECUTER;
                    OP_ITYPE:          state_d = S_EXECUTEI;
                    OP_BRANCH:         state_d = S_BEQ;
                    default:           state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = MemReady ? S_MEMWB : S_MEMREAD;
            S_MEMWB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_MEMWRITE: begin
                state_d = MemReady ? S_FETCH : S_MEMWRITE;
                retire  = MemReady;
            end
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB, S_BEQ: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        PCWrite   = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        MemWrite  = 1'b0;
        MemRead   = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RS2;
        ALUOp     = ALUOP_ADD;
        ImmSrc    = IMM_NONE;
        IllegalOp = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRead   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                IRWrite   = MemReady;
                PCWrite   = MemReady;
            end
            // Branch target is precomputed here so BEQ only has to compare.
            S_DECODE: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_IMM;
                ImmSrc    = IMM_B;
                IllegalOp = !is_supported(opcode);
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = (opcode == OP_LOAD) ? IMM_I : IMM_S;
            end
            S_MEMREAD: begin
                AdrSrc  = 1'b1;
                MemRead = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = RES_READDATA;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_RS2;
                ALUOp   = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = IMM_I;
                ALUOp   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ResultSrc = RES_ALUOUT;
                RegWrite  = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA   = SRCA_RS1;
                ALUSrcB   = SRCB_RS2;
                ALUOp     = ALUOP_SUB;
                ResultSrc = RES_ALUOUT;
                PCWrite   = Zero;
            end
            default: ;
        endcase
        if (rst) begin
            PCWrite   = 1'b0;
            IRWrite   = 1'b0;
            RegWrite  = 1'b0;
            MemWrite  = 1'b0;
            MemRead   = 1'b0;
            IllegalOp = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire)
                retired_q <= retired_q + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - directed self-checking bench for multicycle_control_fsm
module tb_multicycle_control_fsm;

    // Field order: PCW IRW RegW MemW MemR AdrSrc ResultSrc ALUSrcA ALUSrcB ALUOp ImmSrc Illegal
    localparam logic [16:0] V_RST      = 17'b0_0_0_0_0_0_10_00_10_00_00_0;
    localparam logic [16:0] V_FETCH_W  = 17'b0_0_0_0_1_0_10_00_10_00_00_0;
    localparam logic [16:0] V_FETCH    = 17'b1_1_0_0_1_0_10_00_10_00_00_0;
    localparam logic [16:0] V_DEC      = 17'b0_0_0_0_0_0_00_01_01_00_11_0;
    localparam logic [16:0] V_DEC_ILL  = 17'b0_0_0_0_0_0_00_01_01_00_11_1;
    localparam logic [16:0] V_MADR_LW  = 17'b0_0_0_0_0_0_00_10_01_00_01_0;
    localparam logic [16:0] V_MADR_SW  = 17'b0_0_0_0_0_0_00_10_01_00_10_0;
    localparam logic [16:0] V_MREAD    = 17'b0_0_0_0_1_1_00_00_00_00_00_0;
    localparam logic [16:0] V_MWB      = 17'b0_0_1_0_0_0_01_00_00_00_00_0;
    localparam logic [16:0] V_MWRITE   = 17'b0_0_0_1_0_1_00_00_00_00_00_0;
    localparam logic [16:0] V_EXR      = 17'b0_0_0_0_0_0_00_10_00_10_00_0;
    localparam logic [16:0] V_EXI      = 17'b0_0_0_0_0_0_00_10_01_10_01_0;
    localparam logic [16:0] V_ALUWB    = 17'b0_0_1_0_0_0_00_00_00_00_00_0;
    localparam logic [16:0] V_BEQ_Z1   = 17'b1_0_0_0_0_0_00_10_00_01_00_0;
    localparam logic [16:0] V_BEQ_Z0   = 17'b0_0_0_0_0_0_00_10_00_01_00_0;

    localparam logic [31:0] I_LW   = 32'h0081_2283;
    localparam logic [31:0] I_SW   = 32'h0050_A223;
    localparam logic [31:0] I_ADD  = 32'h0020_81B3;
    localparam logic [31:0] I_ADDI = 32'h0010_8093;
    localparam logic [31:0] I_BEQ  = 32'hFE20_8CE3;
    localparam logic [31:0] I_ILL  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        Zero;
    logic        MemReady;
    logic        PCWrite, IRWrite, RegWrite, MemWrite, MemRead, AdrSrc, IllegalOp;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
    logic [31:0] InstrRetired;
    logic [16:0] outs;

    int total = 0;
    int bad   = 0;

    multicycle_control_fsm #(.DATA_WIDTH(32), .STATE_W(4)) dut (
        .clk(clk), .rst(rst), .instr(instr), .Zero(Zero), .MemReady(MemReady),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .MemRead(MemRead), .AdrSrc(AdrSrc),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .ImmSrc(ImmSrc), .IllegalOp(IllegalOp),
        .InstrRetired(InstrRetired)
    );

    assign outs = {PCWrite, IRWrite, RegWrite, MemWrite, MemRead, AdrSrc,
                   ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, IllegalOp};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge: drive inputs for the coming rising edge, check, advance.
    task automatic cyc(input string tag, input logic mr, input logic z, input logic [16:0] exp);
        MemReady = mr;
        Zero     = z;
        #1;
        check(tag, {15'd0, outs}, {15'd0, exp});
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; instr = I_LW; Zero = 1'b0; MemReady = 1'b1;
        #1;
        check("reset_outs", {15'd0, outs}, {15'd0, V_RST});
        check("reset_count", InstrRetired, 32'd0);
        repeat (2) @(negedge clk);
        check("reset_hold_outs", {15'd0, outs}, {15'd0, V_RST});
        rst = 1'b0;

        cyc("lw_fetch",  1'b1, 1'b0, V_FETCH);
        cyc("lw_decode", 1'b1, 1'b0, V_DEC);
        cyc("lw_memadr", 1'b1, 1'b0, V_MADR_LW);
        cyc("lw_memread",1'b1, 1'b0, V_MREAD);
        check("lw_count_before", InstrRetired, 32'd0);
        cyc("lw_memwb",  1'b1, 1'b0, V_MWB);
        check("lw_count_after", InstrRetired, 32'd1);

        instr = I_SW;
        cyc("sw_fetch",  1'b1, 1'b0, V_FETCH);
        cyc("sw_decode", 1'b1, 1'b0, V_DEC);
        cyc("sw_memadr", 1'b1, 1'b0, V_MADR_SW);
        for (int i = 0; i < 3; i++) begin
            cyc("sw_memwrite_wait", 1'b0, 1'b0, V_MWRITE);
            check("sw_no_early_retire", InstrRetired, 32'd1);
        end
        cyc("sw_memwrite_done", 1'b1, 1'b0, V_MWRITE);
        check("sw_count", InstrRetired, 32'd2);

        instr = I_ADD;
        cyc("add_fetch",  1'b1, 1'b0, V_FETCH);
        cyc("add_decode", 1'b1, 1'b0, V_DEC);
        cyc("add_execr",  1'b1, 1'b0, V_EXR);
        cyc("add_aluwb",  1'b1, 1'b0, V_ALUWB);
        check("add_count", InstrRetired, 32'd3);

        instr = I_ADDI;
        cyc("addi_fetch",  1'b1, 1'b0, V_FETCH);
        cyc("addi_decode", 1'b1, 1'b0, V_DEC);
        cyc("addi_execi",  1'b1, 1'b0, V_EXI);
        cyc("addi_aluwb",  1'b1, 1'b0, V_ALUWB);
        check("addi_count", InstrRetired, 32'd4);

        instr = I_BEQ;
        cyc("beq1_fetch",  1'b1, 1'b0, V_FETCH);
        cyc("beq1_decode", 1'b1, 1'b0, V_DEC);
        cyc("beq1_taken",  1'b1, 1'b1, V_BEQ_Z1);
        check("beq1_count", InstrRetired, 32'd5);
        cyc("beq0_fetch",  1'b1, 1'b0, V_FETCH);
        cyc("beq0_decode", 1'b1, 1'b0, V_DEC);
        cyc("beq0_nottaken", 1'b1, 1'b0, V_BEQ_Z0);
        check("beq0_count", InstrRetired, 32'd6);

        instr = I_ILL;
        cyc("ill_fetch_wait0", 1'b0, 1'b0, V_FETCH_W);
        cyc("ill_fetch_wait1", 1'b0, 1'b0, V_FETCH_W);
        cyc("ill_fetch",  1'b1, 1'b0, V_FETCH);
        cyc("ill_decode", 1'b1, 1'b0, V_DEC_ILL);
        check("ill_count", InstrRetired, 32'd6);

        instr = I_LW;
        cyc("rlw_fetch",  1'b1, 1'b0, V_FETCH);
        cyc("rlw_decode", 1'b1, 1'b0, V_DEC);
        cyc("rlw_memadr", 1'b1, 1'b0, V_MADR_LW);
        cyc("rlw_memread_wait", 1'b0, 1'b0, V_MREAD);
        MemReady = 1'b1;
        rst = 1'b1;
        #1;
        check("rst_mid_outs", {15'd0, outs}, {15'd0, V_RST});
        check("rst_mid_count", InstrRetired, 32'd0);
        @(negedge clk);
        check("rst_mid_hold", {15'd0, outs}, {15'd0, V_RST});
        rst = 1'b0;
        cyc("post_rst_fetch",  1'b1, 1'b0, V_FETCH);
        cyc("post_rst_decode", 1'b1, 1'b0, V_DEC);
        check("post_rst_count", InstrRetired, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
